// File: rtl/rpn_eval.sv
// RPN ASCII evaluator: signed WIDTH-bit stack machine, decimal result out with LF terminator.
// Optional macro RPN_EVAL_MOD_EN makes '%' a signed-remainder operator; otherwise '%' is a separator.
module rpn_eval #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int MAXDIG = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_STB,
  input  logic [7:0] IN_CHAR,
  output logic       IN_ACK,
  output logic       OUT_STB,
  output logic [7:0] OUT_CHAR,
  input  logic       OUT_ACK,
  output logic [3:0] dbg_state
);

  // Both sides: a character moves on any cycle where STB && ACK are high at the clock edge.
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = (MAXDIG > 1) ? $clog2(MAXDIG) : 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [3:0] {
    S_ACCEPT, S_PUSH, S_EXEC, S_FINISH, S_CONV,
    S_EMIT_SIGN, S_EMIT_DIG, S_EMIT_LF, S_EMIT_ERR
  } state_t;

  state_t state, state_next;

  logic signed [WIDTH-1:0] stack [DEPTH];
  logic [DW-1:0]    depth;
  logic [WIDTH-1:0] acc;
  logic             pending;
  logic             err;
  logic [7:0]       ch;
  logic [WIDTH-1:0] mag;
  logic             neg;
  logic [3:0]       dbuf [MAXDIG];
  logic [IW-1:0]    ndig;
  logic [IW-1:0]    idx;

  logic [AW-1:0]           top_idx, sec_idx;
  logic signed [WIDTH-1:0] op_a, op_b, top_val, alu_res;
  logic                    alu_bad;
  logic [WIDTH-1:0]        mag_div;
  logic [3:0]              mag_dig;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_op(input logic [7:0] c);
    logic r;
    r = (c == 8'h2b) || (c == 8'h2d) || (c == 8'h2a) || (c == 8'h2f);
`ifdef RPN_EVAL_MOD_EN
    r = r || (c == 8'h25);
`endif
    return r;
  endfunction

  function automatic state_t dispatch(input logic [7:0] c);
    if (is_op(c))       return S_EXEC;
    else if (c == 8'h3d) return S_FINISH;
    else                return S_ACCEPT;
  endfunction

  assign dbg_state = state;
  assign top_idx   = AW'(depth - DW'(1));
  assign sec_idx   = AW'(depth - DW'(2));
  assign op_a      = stack[sec_idx];
  assign op_b      = stack[top_idx];
  assign top_val   = stack[top_idx];
  assign mag_div   = mag / WIDTH'(10);
  assign mag_dig   = 4'(mag % WIDTH'(10));

  // Division overflow (most-negative / -1) is pinned explicitly rather than left to the divider.
  always_comb begin
    alu_res = '0;
    alu_bad = 1'b0;
    case (ch)
      8'h2b: alu_res = op_a + op_b;
      8'h2d: alu_res = op_a - op_b;
      8'h2a: alu_res = op_a * op_b;
      8'h2f: begin
        if (op_b == '0) alu_bad = 1'b1;
        else if (op_a == MOST_NEG && op_b == '1) alu_res = MOST_NEG;
        else alu_res = op_a / op_b;
      end
`ifdef RPN_EVAL_MOD_EN
      8'h25: begin
        if (op_b == '0) alu_bad = 1'b1;
        else if (op_a == MOST_NEG && op_b == '1) alu_res = '0;
        else alu_res = op_a % op_b;
      end
`endif
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_ACCEPT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    IN_ACK     = 1'b0;
    OUT_STB    = 1'b0;
    OUT_CHAR   = 8'h00;
    case (state)
      S_ACCEPT: begin
        IN_ACK = 1'b1;
        if (IN_STB && !is_digit(IN_CHAR))
          state_next = pending ? S_PUSH : dispatch(IN_CHAR);
      end
      S_PUSH:   state_next = dispatch(ch);
      S_EXEC:   state_next = S_ACCEPT;
      S_FINISH: state_next = (err || depth != DW'(1)) ? S_EMIT_ERR : S_CONV;
      S_CONV: begin
        if (mag_div == '0) state_next = neg ? S_EMIT_SIGN : S_EMIT_DIG;
      end
      S_EMIT_SIGN: begin
        OUT_STB  = 1'b1;
        OUT_CHAR = 8'h2d;
        if (OUT_ACK) state_next = S_EMIT_DIG;
      end
      S_EMIT_DIG: begin
        OUT_STB  = 1'b1;
        OUT_CHAR = {4'h3, dbuf[idx]};
        if (OUT_ACK && idx == '0) state_next = S_EMIT_LF;
      end
      S_EMIT_LF: begin
        OUT_STB  = 1'b1;
        OUT_CHAR = 8'h0a;
        if (OUT_ACK) state_next = S_ACCEPT;
      end
      S_EMIT_ERR: begin
        OUT_STB  = 1'b1;
        OUT_CHAR = 8'h45;
        if (OUT_ACK) state_next = S_EMIT_LF;
      end
      default: state_next = S_ACCEPT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      depth   <= '0;
      acc     <= '0;
      pending <= 1'b0;
      err     <= 1'b0;
      ch      <= 8'h00;
      mag     <= '0;
      neg     <= 1'b0;
      ndig    <= '0;
      idx     <= '0;
    end else begin
      case (state)
        S_ACCEPT: begin
          if (IN_STB) begin
            if (is_digit(IN_CHAR)) begin
              acc     <= acc * WIDTH'(10) + {{(WIDTH-4){1'b0}}, IN_CHAR[3:0]};
              pending <= 1'b1;
            end else begin
              ch <= IN_CHAR;
            end
          end
        end
        S_PUSH: begin
          if (!err) begin
            if (depth == DW'(DEPTH)) err <= 1'b1;
            else depth <= depth + DW'(1);
          end
          acc     <= '0;
          pending <= 1'b0;
        end
        S_EXEC: begin
          if (!err) begin
            if (depth < DW'(2) || alu_bad) err <= 1'b1;
            else depth <= depth - DW'(1);
          end
        end
        S_FINISH: begin
          neg  <= top_val[WIDTH-1];
          mag  <= top_val[WIDTH-1] ? (~top_val + WIDTH'(1)) : top_val;
          ndig <= '0;
        end
        S_CONV: begin
          dbuf[ndig] <= mag_dig;
          mag        <= mag_div;
          ndig       <= ndig + IW'(1);
          idx        <= ndig;
        end
        S_EMIT_DIG: begin
          if (OUT_ACK && idx != '0) idx <= idx - IW'(1);
        end
        S_EMIT_LF: begin
          if (OUT_ACK) begin
            depth   <= '0;
            err     <= 1'b0;
            acc     <= '0;
            pending <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Stack contents need no reset: depth alone defines which entries are live.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state == S_PUSH && !err && depth != DW'(DEPTH))
        stack[AW'(depth)] <= acc;
      else if (state == S_EXEC && !err && depth >= DW'(2) && !alu_bad)
        stack[sec_idx] <= alu_res;
    end
  end

endmodule

// File: doc/rpn_eval.md
Name: rpn_eval

Overview:
- Stack-based evaluator directly downstream of the infix-to-RPN converter (`onp`).
- Consumes its RPN ASCII character stream, evaluates it on a signed integer stack, and emits the decimal ASCII result terminated by LF.
- Uses the same STB/ACK character handshake on both sides, so it chains directly onto the converter output and into the display/UART stage.

Parameters:
- WIDTH, 16, operand/stack word width, two's complement.
- DEPTH, 8, stack entries.
- MAXDIG, 5, decimal digit buffer size; must hold the digits of 2^(WIDTH-1).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- IN_STB  in  1  input character valid.
- IN_CHAR  in  8  input ASCII character.
- IN_ACK  out  1  ready/idle; a character is taken on any cycle with IN_STB && IN_ACK.
- OUT_STB  out  1  output character valid.
- OUT_CHAR  out  8  output ASCII character.
- OUT_ACK  in  1  output character taken; consumer asserts it while OUT_STB is high.

Behaviour:
- Clock and reset:
  - One clock, CLK. Reset RST is synchronous, active-high.
  - Reset: stack empty (depth 0), accumulator 0, number-pending flag 0, error flag 0, state ACCEPT, IN_ACK=1, OUT_STB=0, OUT_CHAR=8'h00.
  - Reset mid-operation aborts everything: OUT_STB is low the cycle after RST.
- Character classes:
  - Digits 8'h30-8'h39.
  - Operators '+' 8'h2b, '-' 8'h2d, '*' 8'h2a, '/' 8'h2f.
  - Terminator '=' 8'h3d.
  - Everything else (space 8'h20, brackets, LF, etc.) is a separator.
- States: ACCEPT, PUSH, EXEC, FINISH, CONV, EMIT_SIGN, EMIT_DIG, EMIT_LF, EMIT_ERR.
- ACCEPT (IN_ACK=1):
  - Digit: acc <= acc*10 + digit, modulo 2^WIDTH; pending <= 1; stay in ACCEPT, so digits stream back-to-back.
  - Non-digit: latched into a char register; IN_ACK drops next cycle.
    - If pending, go to PUSH.
    - Else operator goes to EXEC, '=' goes to FINISH, separator stays in ACCEPT.
- PUSH (1 cycle):
  - If depth==DEPTH, set err; else push acc and depth++.
  - acc <= 0, pending <= 0.
  - Then dispatch the latched char as in ACCEPT.
- EXEC (1 cycle):
  - If err is set, no-op.
  - depth<2 sets err.
  - Otherwise pop b (top) and a, push a op b, depth-1.
  - '+', '-', '*': wrap modulo 2^WIDTH.
  - '/': signed, truncates toward zero; b==0 sets err.
  - Most-negative / -1 wraps to most-negative.
  - Returns to ACCEPT.
- FINISH:
  - err or depth!=1 goes to EMIT_ERR.
  - Else latch magnitude and sign of the top entry and go to CONV.
- CONV:
  - One digit per cycle via %10 and /10 of the magnitude into the digit buffer.
  - Ends when the quotient is 0; at least one digit, so 0 yields "0".
  - Negative goes to EMIT_SIGN, else EMIT_DIG.
- Output sequence:
  - EMIT_SIGN: '-'.
  - EMIT_DIG: digits most significant first.
  - EMIT_LF: 8'h0a.
  - EMIT_ERR: 'E' (8'h45), then EMIT_LF.
- Output handshake:
  - OUT_CHAR is valid with OUT_STB and held stable until the cycle OUT_ACK is sampled high.
  - The next character is presented the following cycle, or OUT_STB drops.
  - OUT_ACK with OUT_STB low is ignored.
- After LF is acknowledged:
  - Stack cleared, err cleared, acc 0.
  - Return to ACCEPT with IN_ACK=1.
- IN_ACK is 0 in every state except ACCEPT; IN_STB is ignored while IN_ACK=0.
- Error flag:
  - Sticky until '=' output completes.
  - While set, digits and operators are still consumed but do not modify the stack.
- Numeric inputs: literals are non-negative only; '-' is always binary subtract.

Optional Feature:
- Macro RPN_EVAL_MOD_EN.
- Defined: '%' (8'h25) is an operator, signed remainder with the sign of the dividend; b==0 sets err; one EXEC cycle.
- Undefined: '%' is a separator with no effect.

Test Plan:
- "12 3+=" with OUT_ACK tied 1 -> output "15",8'h0a; IN_ACK high again the cycle after LF is acknowledged.
- "2 3-=" -> "-1",8'h0a. Separately, "0 7-2/=" -> "-3",8'h0a (truncation toward zero).
- "7 0/=" -> "E",8'h0a. Separately, "1 2=" (depth 2) -> "E",8'h0a. Separately, "+=" (underflow) -> "E",8'h0a. In all three, the next expression "4=" -> "4",8'h0a (error cleared).
- Overflow and wrap:
  - Nine single-digit literals then "=" with DEPTH=8 -> "E",8'h0a.
  - "32767 1+=" -> "-32768",8'h0a.
  - "0=" -> "0",8'h0a.
- Backpressure: "123=" with OUT_ACK pulsed every 3rd cycle -> each of '1','2','3',LF held stable until its acknowledge, no duplicates or drops.
- RST for one cycle during EMIT_DIG of "999=" -> OUT_STB 0 next cycle; a following "5=" -> "5",8'h0a.
- With RPN_EVAL_MOD_EN: "17 5%=" -> "2",8'h0a. Without it, the same input -> "E",8'h0a.
